pc_update: RTL and testbench
============================

// Module: pc_update
// PURPOSE
//   Y86-64 single-cycle PC-update stage and processor status holder. Owns the architectural PC
//   register that drives fetch PC_i. Each stepped cycle it selects the next PC from the results of
//   fetch, execute and memory, and tracks processor status (AOK/HLT/ADR/INS). It freezes the machine
//   on halt or on any fault, and counts retired instructions.
// PARAMETERS
//   RESET_PC  64'd0  PC value loaded on reset
//   CNT_W     32     width of retired-instruction counter (and perf counters when enabled)
// PORTS
//   clk_i          in   1      clock, all state updates on rising edge
//   rst_n_i        in   1      asynchronous active-low reset
//   step_i         in   1      1 = commit current instruction this edge; 0 = hold all state
//   icode_i        in   4      instruction code from fetch
//   cnd_i          in   1      condition result from execute (1 for unconditional jmp)
//   valC_i         in   64     constant/destination from fetch
//   valP_i         in   64     sequential next PC from fetch
//   valM_i         in   64     value read from memory (return address for ret)
//   instr_valid_i  in   1      fetch decoded a legal icode
//   imem_error_i   in   1      fetch address fault
//   dmem_error_i   in   1      memory-stage address fault
//   PC_o           out  64     current PC, feeds fetch PC_i
//   stat_o         out  3      AOK=3'd1, HLT=3'd2, ADR=3'd3, INS=3'd4
//   halted_o       out  1      1 when state is STOP
//   retired_o      out  CNT_W  count of committed instructions
// BEHAVIOUR
//   - Reset (async, any time, including mid-step): PC_o=RESET_PC, stat_o=AOK, halted_o=0,
//     retired_o=0, state=RUN. The first edge after release may commit.
//   - FSM: RUN, STOP. STOP exits only via reset. In STOP all outputs hold and step_i is ignored.
//   - In RUN with step_i=0: nothing changes.
//   - In RUN with step_i=1, the status for this cycle (new_stat) is chosen by priority:
//     imem_error_i -> ADR; !instr_valid_i -> INS; dmem_error_i -> ADR; icode==IHALT(0) -> HLT;
//     else AOK.
//   - new_stat==AOK:
//     - PC_o <= next_pc, where next_pc is:
//       - ICALL(8): valC_i
//       - IJXX(7) with cnd_i=1: valC_i
//       - IRET(9): valM_i
//       - otherwise: valP_i
//     - retired_o += 1. State stays RUN.
//   - new_stat==HLT: PC_o holds the halt address, retired_o += 1, stat_o<=HLT, state->STOP.
//   - new_stat ADR/INS: PC_o holds the faulting address, retired_o unchanged, stat_o<=new_stat,
//     state->STOP.
//   - Output update timing: stat_o and halted_o update on the same edge as the transition.
//     Latency is one edge from step_i to the new PC_o.
//   - Arithmetic: PC is a 64-bit plain register with no arithmetic of its own; valP_i wrap is
//     fetch's concern.
//   - retired_o wraps modulo 2^CNT_W, with no saturation.
//   - Input fields (icode_i, cnd_i, val*_i) are don't-care when step_i=0 or in STOP.
// CONFIGURATION
//   PC_UPDATE_PERF_EN defined:
//     - adds out ports cycles_o[CNT_W] and taken_o[CNT_W], both reset to 0.
//     - cycles_o counts every edge in RUN, regardless of step_i.
//     - taken_o counts committed AOK cycles with ICALL, IRET, or IJXX with cnd_i=1.
//     - Both freeze in STOP and wrap modulo 2^CNT_W.
//   Not defined: the ports and counters do not exist; all other behaviour is identical.
// TESTING
//   1. Release reset and hold step_i=0 for 3 edges -> PC_o=0, stat_o=1, retired_o=0, halted_o=0.
//   2. Sequential, unconditional jump and call:
//      - step with icode=3, valP=10 -> PC_o=10, retired_o=1.
//      - then icode=7, cnd=1, valC=0x40 -> PC_o=0x40.
//      - then icode=8, valC=0x80 -> PC_o=0x80.
//   3. Branch not taken and return:
//      - icode=7, cnd=0, valC=0x40, valP=0x49 -> PC_o=0x49.
//      - icode=9, valM=0x1C -> PC_o=0x1C.
//   4. Halt: PC_o=0x20, icode=0, step -> stat_o=2, halted_o=1, PC_o=0x20.
//      Further steps with icode=3 change nothing.
//   5. Fault priority:
//      - imem_error=1 with instr_valid=0 -> stat_o=3, retired_o unchanged.
//      - After reset, instr_valid=0 with dmem_error=1 -> stat_o=4.
//   6. Reset mid-run: assert rst_n_i low between edges -> PC_o=RESET_PC immediately, before any
//      edge. With PERF_EN, cycles_o=0 and taken_o=0.

Source files
------------

// File: rtl/pc_update.sv
// ============================================================================
// Module   : pc_update
// Brief    : Y86-64 PC-update stage and processor status holder. The optional
//            performance counters are built when PC_UPDATE_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_update #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             step_i,
  input  logic [3:0]       icode_i,
  input  logic             cnd_i,
  input  logic [63:0]      valC_i,
  input  logic [63:0]      valP_i,
  input  logic [63:0]      valM_i,
  input  logic             instr_valid_i,
  input  logic             imem_error_i,
  input  logic             dmem_error_i,
  output logic [63:0]      PC_o,
  output logic [2:0]       stat_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] retired_o
`ifdef PC_UPDATE_PERF_EN
  ,
  output logic [CNT_W-1:0] cycles_o,
  output logic [CNT_W-1:0] taken_o
`endif
);

  localparam logic [2:0] c_stat_aok = 3'd1;
  localparam logic [2:0] c_stat_hlt = 3'd2;
  localparam logic [2:0] c_stat_adr = 3'd3;
  localparam logic [2:0] c_stat_ins = 3'd4;

  localparam logic [3:0] c_ihalt = 4'd0;
  localparam logic [3:0] c_ijxx  = 4'd7;
  localparam logic [3:0] c_icall = 4'd8;
  localparam logic [3:0] c_iret  = 4'd9;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_STOP = 1'b1
  } state_t;

  state_t           r_state;
  logic [63:0]      r_pc;
  logic [2:0]       r_stat;
  logic             r_halted;
  logic [CNT_W-1:0] r_retired;
  logic [2:0]       w_new_stat;
  logic [63:0]      w_next_pc;

  // Fetch faults outrank decode faults, which outrank memory faults and halt.
  always_comb begin
    w_new_stat = c_stat_aok;
    if (imem_error_i)        w_new_stat = c_stat_adr;
    else if (!instr_valid_i) w_new_stat = c_stat_ins;
    else if (dmem_error_i)   w_new_stat = c_stat_adr;
    else if (icode_i == c_ihalt) w_new_stat = c_stat_hlt;
  end

  always_comb begin
    w_next_pc = valP_i;
    if (icode_i == c_icall)                 w_next_pc = valC_i;
    else if (icode_i == c_ijxx && cnd_i)    w_next_pc = valC_i;
    else if (icode_i == c_iret)             w_next_pc = valM_i;
  end

`ifdef PC_UPDATE_PERF_EN
  logic             w_taken;
  logic [CNT_W-1:0] r_cycles;
  logic [CNT_W-1:0] r_taken;

  assign w_taken = (icode_i == c_icall) || (icode_i == c_iret) ||
                   ((icode_i == c_ijxx) && cnd_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cycles <= '0;
      r_taken  <= '0;
    end else if (r_state == ST_RUN) begin
      r_cycles <= r_cycles + 1'b1;
      if (step_i && w_new_stat == c_stat_aok && w_taken)
        r_taken <= r_taken + 1'b1;
    end
  end

  assign cycles_o = r_cycles;
  assign taken_o  = r_taken;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= ST_RUN;
      r_pc      <= RESET_PC;
      r_stat    <= c_stat_aok;
      r_halted  <= 1'b0;
      r_retired <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (step_i) begin
            if (w_new_stat == c_stat_aok) begin
              r_pc      <= w_next_pc;
              r_retired <= r_retired + 1'b1;
            end else begin
              // PC stays on the halting/faulting instruction for diagnosis.
              r_stat   <= w_new_stat;
              r_halted <= 1'b1;
              r_state  <= ST_STOP;
              if (w_new_stat == c_stat_hlt)
                r_retired <= r_retired + 1'b1;
            end
          end
        end
        default: r_state <= ST_STOP;
      endcase
    end
  end

  assign PC_o      = r_pc;
  assign stat_o    = r_stat;
  assign halted_o  = r_halted;
  assign retired_o = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_pc_update.sv
// ============================================================================
// Module   : tb_pc_update
// Brief    : Self-checking bench for pc_update, directed plus random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_update;

  localparam int          CNT_W    = 32;
  localparam logic [63:0] RESET_PC = 64'd0;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             step = 1'b0;
  logic [3:0]       icode = '0;
  logic             cnd = 1'b0;
  logic [63:0]      valC = '0, valP = '0, valM = '0;
  logic             instr_valid = 1'b1, imem_error = 1'b0, dmem_error = 1'b0;
  logic [63:0]      pc;
  logic [2:0]       stat;
  logic             halted;
  logic [CNT_W-1:0] retired;
`ifdef PC_UPDATE_PERF_EN
  logic [CNT_W-1:0] cycles, taken;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0]      m_pc;
  logic [2:0]       m_stat;
  logic             m_stop;
  logic [CNT_W-1:0] m_retired, m_cycles, m_taken;

  pc_update #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .step_i(step), .icode_i(icode), .cnd_i(cnd),
    .valC_i(valC), .valP_i(valP), .valM_i(valM), .instr_valid_i(instr_valid),
    .imem_error_i(imem_error), .dmem_error_i(dmem_error),
    .PC_o(pc), .stat_o(stat), .halted_o(halted), .retired_o(retired)
`ifdef PC_UPDATE_PERF_EN
    , .cycles_o(cycles), .taken_o(taken)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = RESET_PC; m_stat = 3'd1; m_stop = 1'b0;
    m_retired = '0; m_cycles = '0; m_taken = '0;
  endtask

  task automatic model_edge();
    logic [2:0] ns;
    if (m_stop) return;
    m_cycles = m_cycles + 1;
    if (!step) return;
    if (imem_error)       ns = 3'd3;
    else if (!instr_valid) ns = 3'd4;
    else if (dmem_error)  ns = 3'd3;
    else if (icode == 0)  ns = 3'd2;
    else                  ns = 3'd1;
    if (ns == 3'd1) begin
      case (icode)
        4'd8:    begin m_pc = valC; m_taken = m_taken + 1; end
        4'd9:    begin m_pc = valM; m_taken = m_taken + 1; end
        4'd7:    if (cnd) begin m_pc = valC; m_taken = m_taken + 1; end
                 else m_pc = valP;
        default: m_pc = valP;
      endcase
      m_retired = m_retired + 1;
    end else begin
      if (ns == 3'd2) m_retired = m_retired + 1;
      m_stat = ns;
      m_stop = 1'b1;
    end
  endtask

  task automatic apply_reset();
    step = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic drive(input logic s, input logic [3:0] ic, input logic c,
                       input logic [63:0] vc, input logic [63:0] vp, input logic [63:0] vm,
                       input logic iv, input logic ie, input logic de);
    step = s; icode = ic; cnd = c; valC = vc; valP = vp; valM = vm;
    instr_valid = iv; imem_error = ie; dmem_error = de;
    @(posedge clk);
    model_edge();
    #1;
    step = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (3) drive(0, 4'd3, 0, 64'h5, 64'h6, 64'h7, 1, 0, 0);
    checks++; if (pc !== 64'd0) begin errors++; $display("FAIL reset_pc got %h want 0", pc); end
    checks++; if (stat !== 3'd1) begin errors++; $display("FAIL reset_stat got %0d want 1", stat); end
    checks++; if (retired !== '0) begin errors++; $display("FAIL reset_retired got %0d want 0", retired); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
  endtask

  task automatic test_seq_jump_call();
    drive(1, 4'd3, 0, 64'h0, 64'd10, 64'h0, 1, 0, 0);
    checks++; if (pc !== 64'd10) begin errors++; $display("FAIL seq_pc got %h want a", pc); end
    checks++; if (retired !== 1) begin errors++; $display("FAIL seq_retired got %0d want 1", retired); end
    drive(1, 4'd7, 1, 64'h40, 64'h13, 64'h0, 1, 0, 0);
    checks++; if (pc !== 64'h40) begin errors++; $display("FAIL jmp_pc got %h want 40", pc); end
    drive(1, 4'd8, 0, 64'h80, 64'h49, 64'h0, 1, 0, 0);
    checks++; if (pc !== 64'h80) begin errors++; $display("FAIL call_pc got %h want 80", pc); end
  endtask

  task automatic test_branch_ret();
    drive(1, 4'd7, 0, 64'h40, 64'h49, 64'h0, 1, 0, 0);
    checks++; if (pc !== 64'h49) begin errors++; $display("FAIL nottaken_pc got %h want 49", pc); end
    drive(1, 4'd9, 1, 64'h55, 64'h4a, 64'h1C, 1, 0, 0);
    checks++; if (pc !== 64'h1C) begin errors++; $display("FAIL ret_pc got %h want 1c", pc); end
    checks++; if (retired !== 5) begin errors++; $display("FAIL ret_retired got %0d want 5", retired); end
  endtask

  task automatic test_halt();
    drive(1, 4'd3, 0, 64'h0, 64'h20, 64'h0, 1, 0, 0);
    drive(1, 4'd0, 0, 64'h0, 64'h21, 64'h0, 1, 0, 0);
    checks++; if (stat !== 3'd2) begin errors++; $display("FAIL halt_stat got %0d want 2", stat); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b want 1", halted); end
    checks++; if (pc !== 64'h20) begin errors++; $display("FAIL halt_pc got %h want 20", pc); end
    checks++; if (retired !== 7) begin errors++; $display("FAIL halt_retired got %0d want 7", retired); end
    repeat (3) drive(1, 4'd3, 0, 64'h0, 64'h99, 64'h0, 1, 0, 0);
    checks++; if (pc !== 64'h20) begin errors++; $display("FAIL stop_pc got %h want 20", pc); end
    checks++; if (stat !== 3'd2) begin errors++; $display("FAIL stop_stat got %0d want 2", stat); end
    checks++; if (retired !== 7) begin errors++; $display("FAIL stop_retired got %0d want 7", retired); end
  endtask

  task automatic test_fault_priority();
    apply_reset();
    drive(1, 4'd3, 0, 64'h0, 64'h10, 64'h0, 1, 0, 0);
    drive(1, 4'd3, 0, 64'h0, 64'h30, 64'h0, 0, 1, 0);
    checks++; if (stat !== 3'd3) begin errors++; $display("FAIL imem_stat got %0d want 3", stat); end
    checks++; if (retired !== 1) begin errors++; $display("FAIL imem_retired got %0d want 1", retired); end
    checks++; if (pc !== 64'h10) begin errors++; $display("FAIL imem_pc got %h want 10", pc); end
    apply_reset();
    drive(1, 4'd3, 0, 64'h0, 64'h30, 64'h0, 0, 0, 1);
    checks++; if (stat !== 3'd4) begin errors++; $display("FAIL ins_stat got %0d want 4", stat); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL ins_halted got %b want 1", halted); end
    apply_reset();
    drive(1, 4'd0, 0, 64'h0, 64'h30, 64'h0, 1, 0, 1);
    checks++; if (stat !== 3'd3) begin errors++; $display("FAIL dmem_over_halt got %0d want 3", stat); end
    checks++; if (retired !== 0) begin errors++; $display("FAIL dmem_retired got %0d want 0", retired); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      if (m_stop && $urandom_range(0, 3) == 0) apply_reset();
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 11)), 1'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 19) != 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 24) == 0);
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rand_pc[%0d] got %h want %h", i, pc, m_pc); end
      checks++; if (stat !== m_stat) begin errors++; $display("FAIL rand_stat[%0d] got %0d want %0d", i, stat, m_stat); end
      checks++; if (halted !== m_stop) begin errors++; $display("FAIL rand_halted[%0d] got %b want %b", i, halted, m_stop); end
      checks++; if (retired !== m_retired) begin errors++; $display("FAIL rand_retired[%0d] got %0d want %0d", i, retired, m_retired); end
`ifdef PC_UPDATE_PERF_EN
      checks++; if (cycles !== m_cycles) begin errors++; $display("FAIL rand_cycles[%0d] got %0d want %0d", i, cycles, m_cycles); end
      checks++; if (taken !== m_taken) begin errors++; $display("FAIL rand_taken[%0d] got %0d want %0d", i, taken, m_taken); end
`endif
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive(1, 4'd8, 0, 64'h777, 64'h5, 64'h0, 1, 0, 0);
    drive(1, 4'd3, 0, 64'h0, 64'h888, 64'h0, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pc !== RESET_PC) begin errors++; $display("FAIL midreset_pc got %h want %h", pc, RESET_PC); end
    checks++; if (retired !== '0) begin errors++; $display("FAIL midreset_retired got %0d want 0", retired); end
    checks++; if (stat !== 3'd1) begin errors++; $display("FAIL midreset_stat got %0d want 1", stat); end
`ifdef PC_UPDATE_PERF_EN
    checks++; if (cycles !== '0) begin errors++; $display("FAIL midreset_cycles got %0d want 0", cycles); end
    checks++; if (taken !== '0) begin errors++; $display("FAIL midreset_taken got %0d want 0", taken); end
`endif
    apply_reset();
    drive(1, 4'd3, 0, 64'h0, 64'h44, 64'h0, 1, 0, 0);
    checks++; if (pc !== 64'h44) begin errors++; $display("FAIL postreset_pc got %h want 44", pc); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_seq_jump_call();
    test_branch_ret();
    test_halt();
    test_fault_priority();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
